// File: rtl/pmod_nav_spi_engine.sv
// Mode-3, MSB-first SPI byte-stream master for the PmodNAV slaves (AG, MAG, ALT).
// A command selects the slave and byte count; bytes then stream through tx/rx handshakes.
module pmod_nav_spi_engine #(
    parameter int CLK_DIV = 4,
    parameter int LEN_W   = 4
) (
    input  logic             s_axi_aclk,
    input  logic             s_axi_aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_dev,
    input  logic [LEN_W-1:0] cmd_nbytes,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             done,
    output logic             spi_io0_o,
    output logic             spi_io0_t,
    input  logic             spi_io1_i,
    output logic             spi_io1_o,
    output logic             spi_io1_t,
    output logic             spi_sck_o,
    output logic             spi_sck_t,
    output logic [2:0]       spi_ss_o,
    output logic             spi_ss_t
);
    localparam int               CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, SETUP, WAIT_TX, SHIFT, HOLD, GAP} state_t;
    state_t state, state_next;

    logic [CNT_W-1:0] div_cnt;
    logic             sck_high;     // SHIFT sub-phase: 0 = SCK low half, 1 = SCK high half
    logic [2:0]       bit_cnt;
    logic [LEN_W-1:0] bytes_left;
    logic [1:0]       dev_q;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       rx_next;
    logic             rx_valid_q;
    logic             done_zero_q;
    logic             pins_driven;
    logic             div_last;
    logic             half_end;
    logic             sample_now;
    logic             byte_end;
    logic             accept;

    assign div_last   = (div_cnt == CNT_LAST);
    assign accept     = (state == IDLE) && cmd_valid;
    assign half_end   = (state == SHIFT) && div_last;
    assign sample_now = (state == SHIFT) && sck_high && (div_cnt == '0);
    assign byte_end   = half_end && sck_high && (bit_cnt == 3'd7);
    // With CLK_DIV=1 the MISO sample and the byte end share one edge, so fold the live bit in.
    assign rx_next    = sample_now ? {rx_sr[6:0], spi_io1_i} : rx_sr;

    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) state <= IDLE;
        else                state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_next = state;
        cmd_ready  = 1'b0;
        tx_ready   = 1'b0;
        done       = done_zero_q;
        spi_sck_o  = 1'b1;
        spi_io0_o  = 1'b1;
        spi_ss_o   = 3'b111;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && (cmd_nbytes != '0)) state_next = SETUP;
            end
            SETUP:   if (div_last) state_next = WAIT_TX;
            WAIT_TX: begin
                tx_ready = 1'b1;
                if (tx_valid) state_next = SHIFT;
            end
            SHIFT: begin
                spi_sck_o = sck_high;
                spi_io0_o = tx_sr[7];
                if (byte_end) state_next = (bytes_left == LEN_W'(1)) ? HOLD : WAIT_TX;
            end
            HOLD:    if (div_last) state_next = GAP;
            GAP: begin
                done = done_zero_q | div_last;
                if (div_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // Device 3 runs the full sequence with no select asserted (dummy clocks).
        if ((state inside {SETUP, WAIT_TX, SHIFT, HOLD}) && (dev_q != 2'd3))
            spi_ss_o[dev_q] = 1'b0;
    end

    // NOTE: registers use non-blocking assignments so each one updates from pre-edge values.
    always_ff @(posedge s_axi_aclk) begin
        if (!s_axi_aresetn) begin
            div_cnt     <= '0;
            sck_high    <= 1'b0;
            bit_cnt     <= '0;
            bytes_left  <= '0;
            dev_q       <= 2'd3;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            rx_valid_q  <= 1'b0;
            done_zero_q <= 1'b0;
            pins_driven <= 1'b0;
        end else begin
            pins_driven <= 1'b1;
            rx_valid_q  <= byte_end;
            done_zero_q <= accept && (cmd_nbytes == '0);
            if ((state_next != state) || div_last) div_cnt <= '0;
            else                                   div_cnt <= div_cnt + CNT_W'(1);
            if (accept) begin
                dev_q      <= cmd_dev;
                bytes_left <= cmd_nbytes;
            end
            if ((state == WAIT_TX) && tx_valid) begin
                tx_sr    <= tx_data;
                sck_high <= 1'b0;
                bit_cnt  <= '0;
            end
            if (half_end) begin
                sck_high <= ~sck_high;
                if (sck_high) begin
                    tx_sr   <= {tx_sr[6:0], 1'b1};
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (sample_now) rx_sr <= rx_next;
            if (byte_end) begin
                rx_data    <= rx_next;
                bytes_left <= bytes_left - LEN_W'(1);
            end
        end
    end

    assign rx_valid  = rx_valid_q;
    assign busy      = (state != IDLE);
    assign spi_io1_o = 1'b0;
    assign spi_io1_t = 1'b1;
    assign spi_io0_t = ~pins_driven;
    assign spi_sck_t = ~pins_driven;
    assign spi_ss_t  = ~pins_driven;

endmodule

// File: tb/tb_pmod_nav_spi_engine.sv
// Directed bench for pmod_nav_spi_engine: CLK_DIV=2 instance for the main scenarios,
// CLK_DIV=1 instance for the fastest SCK; mode-3 slave models feed MISO.
`timescale 1ns/1ps
module tb_pmod_nav_spi_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    int passed = 0;
    int total  = 0;

    // CLK_DIV=2 instance
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [1:0] cmd_dev = 2'd0;
    logic [3:0] cmd_nbytes = 4'd0;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       tx_valid = 1'b0, tx_ready, rx_valid, busy, done;
    logic       io0_o, io0_t, io1_o, io1_t, sck_o, sck_t, ss_t;
    logic [2:0] ss_o;
    logic       miso = 1'b1;

    pmod_nav_spi_engine #(.CLK_DIV(2), .LEN_W(4)) dut (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dev(cmd_dev), .cmd_nbytes(cmd_nbytes),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done),
        .spi_io0_o(io0_o), .spi_io0_t(io0_t), .spi_io1_i(miso), .spi_io1_o(io1_o), .spi_io1_t(io1_t),
        .spi_sck_o(sck_o), .spi_sck_t(sck_t), .spi_ss_o(ss_o), .spi_ss_t(ss_t)
    );

    // CLK_DIV=1 instance
    logic       cmd_valid_f = 1'b0, cmd_ready_f;
    logic [7:0] tx_data_f = 8'h00, rx_data_f;
    logic       tx_valid_f = 1'b0, tx_ready_f, rx_valid_f, busy_f, done_f;
    logic       io0_o_f, io0_t_f, io1_o_f, io1_t_f, sck_f, sck_t_f, ss_t_f;
    logic [2:0] ss_f;
    logic       miso_f = 1'b1;

    pmod_nav_spi_engine #(.CLK_DIV(1), .LEN_W(4)) dut_f (
        .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
        .cmd_valid(cmd_valid_f), .cmd_ready(cmd_ready_f), .cmd_dev(2'd0), .cmd_nbytes(4'd1),
        .tx_data(tx_data_f), .tx_valid(tx_valid_f), .tx_ready(tx_ready_f),
        .rx_data(rx_data_f), .rx_valid(rx_valid_f), .busy(busy_f), .done(done_f),
        .spi_io0_o(io0_o_f), .spi_io0_t(io0_t_f), .spi_io1_i(miso_f), .spi_io1_o(io1_o_f), .spi_io1_t(io1_t_f),
        .spi_sck_o(sck_f), .spi_sck_t(sck_t_f), .spi_ss_o(ss_f), .spi_ss_t(ss_t_f)
    );

    // Slave models: MISO changes on SCK falling edges, bits taken MSB-first from *_word;
    // the bit pointer restarts whenever a new command leaves IDLE.
    logic [31:0] miso_word = 32'h0, miso_word_f = 32'h0;
    int miso_idx = 0, miso_idx_f = 0;
    always @(negedge sck_o or negedge cmd_ready) begin
        if (sck_o === 1'b1) miso_idx = 0;
        else if (miso_idx < 32) begin miso = miso_word[31 - miso_idx]; miso_idx++; end
    end
    always @(negedge sck_f or negedge cmd_ready_f) begin
        if (sck_f === 1'b1) miso_idx_f = 0;
        else if (miso_idx_f < 32) begin miso_f = miso_word_f[31 - miso_idx_f]; miso_idx_f++; end
    end

    // MOSI as seen by a mode-3 slave: captured on SCK rising edges.
    logic [31:0] mosi_sr = 32'h0;
    logic [7:0]  mosi_f = 8'h0;
    int mosi_n = 0;
    always @(posedge sck_o) begin mosi_sr = {mosi_sr[30:0], io0_o}; mosi_n++; end
    always @(posedge sck_f) mosi_f = {mosi_f[6:0], io0_o_f};

    // Cycle monitor, sampled on the falling clock edge; counters only ever increase.
    int cyc = 0, ss_ag = 0, ss_mag = 0, ss_alt = 0, ss_bad = 0;
    int done_n = 0, rxv_n = 0, sck_tog = 0, stall_bad = 0, txr_n = 0, busy_n = 0;
    int hi_run = 0, last_gap = 0;
    bit seen_low = 1'b0;
    logic [7:0] rx_last = 8'h0, rx_prev = 8'h0;
    logic prev_sck = 1'b1, prev_sck_f = 1'b1;
    int f_tog = 0, f_low_n = 0, f_first_low_cyc = 0, f_rxv_cyc = 0;
    always @(negedge clk) begin
        cyc++;
        case (ss_o)
            3'b110:  ss_ag++;
            3'b101:  ss_mag++;
            3'b011:  ss_alt++;
            3'b111:  ;
            default: ss_bad++;
        endcase
        if (ss_o !== 3'b111) begin
            if (seen_low && hi_run > 0) last_gap = hi_run;
            hi_run = 0;
            seen_low = 1'b1;
        end else hi_run++;
        if (done === 1'b1) done_n++;
        if (busy === 1'b1) busy_n++;
        if (rx_valid === 1'b1) begin rxv_n++; rx_prev = rx_last; rx_last = rx_data; end
        if (sck_o !== prev_sck) sck_tog++;
        prev_sck = sck_o;
        if (tx_ready === 1'b1) begin
            txr_n++;
            if (sck_o !== 1'b1 || ss_o === 3'b111) stall_bad++;
        end
        if (sck_f !== prev_sck_f) f_tog++;
        prev_sck_f = sck_f;
        if (sck_f === 1'b0) begin
            if (f_low_n == 0) f_first_low_cyc = cyc;
            f_low_n++;
        end
        if (rx_valid_f === 1'b1) f_rxv_cyc = cyc;
    end

    task automatic issue_cmd(input logic [1:0] dev, input logic [3:0] n);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_dev = dev; cmd_nbytes = n;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            tx_data = d; tx_valid = 1'b1;
            @(posedge clk); #1;
            tx_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({ss_o, sck_o, io0_o, io1_o, io1_t, io0_t, sck_t, ss_t, busy, done, rx_valid, tx_ready} !== 14'b111_1_1_0_1_1_1_1_0_0_0_0)
            $display("FAIL reset_outputs: got %b expected %b", {ss_o, sck_o, io0_o, io1_o, io1_t, io0_t, sck_t, ss_t, busy, done, rx_valid, tx_ready}, 14'b111_1_1_0_1_1_1_1_0_0_0_0); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else passed++;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if ({io0_t, sck_t, ss_t, io1_t, cmd_ready} !== 5'b0_0_0_1_1)
            $display("FAIL release_tristates: got %b expected 00011", {io0_t, sck_t, ss_t, io1_t, cmd_ready}); else passed++;
    endtask

    task automatic test_single_ag();
        int b_ag, b_done, b_rxv, b_tog, b_mosi;
        bit ok;
        miso_word = 32'h6800_0000;
        b_ag = ss_ag; b_done = done_n; b_rxv = rxv_n; b_tog = sck_tog; b_mosi = mosi_n;
        issue_cmd(2'd0, 4'd1);
        send_byte(8'h8F, ok);
        total++; if (!ok) $display("FAIL ag_tx_ready_timeout: got no tx_ready expected tx_ready"); else passed++;
        wait_done(ok);
        total++; if (!ok) $display("FAIL ag_done_timeout: got no done expected done"); else passed++;
        @(negedge clk);
        // SETUP 2 + one WAIT_TX cycle + 32 SHIFT + HOLD 2
        total++; if (ss_ag - b_ag !== 37) $display("FAIL ag_cs_cycles: got %0d expected 37", ss_ag - b_ag); else passed++;
        total++; if (ss_bad !== 0) $display("FAIL ag_cs_onehot: got %0d bad cycles expected 0", ss_bad); else passed++;
        total++; if (mosi_n - b_mosi !== 8 || mosi_sr[7:0] !== 8'h8F)
            $display("FAIL ag_mosi: got %h (%0d bits) expected 8f (8 bits)", mosi_sr[7:0], mosi_n - b_mosi); else passed++;
        total++; if (sck_tog - b_tog !== 16) $display("FAIL ag_sck_edges: got %0d expected 16", sck_tog - b_tog); else passed++;
        total++; if (rx_data !== 8'h68 || rxv_n - b_rxv !== 1)
            $display("FAIL ag_rx: got %h (%0d pulses) expected 68 (1 pulse)", rx_data, rxv_n - b_rxv); else passed++;
        total++; if (done_n - b_done !== 1) $display("FAIL ag_done_once: got %0d expected 1", done_n - b_done); else passed++;
    endtask

    task automatic test_mag_stall();
        int b_mag, b_ag, b_alt, b_rxv, b_txr, b_done;
        bit ok, rdy;
        miso_word = 32'hA53C_0000;
        b_mag = ss_mag; b_ag = ss_ag; b_alt = ss_alt; b_rxv = rxv_n; b_txr = txr_n; b_done = done_n;
        issue_cmd(2'd1, 4'd2);
        send_byte(8'hCF, ok);
        rdy = 1'b0;
        for (int i = 0; i < 200 && !rdy; i++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) rdy = 1'b1;
        end
        total++; if (!(ok && rdy)) $display("FAIL mag_tx_ready_timeout: got no tx_ready expected tx_ready"); else passed++;
        repeat (10) @(negedge clk);
        send_byte(8'h00, ok);
        wait_done(ok);
        total++; if (!ok) $display("FAIL mag_done_timeout: got no done expected done"); else passed++;
        @(negedge clk);
        // WAIT_TX: 1 cycle for byte 0, 12 cycles (1 + 10 stalled + 1) for byte 1
        total++; if (txr_n - b_txr !== 13) $display("FAIL mag_wait_cycles: got %0d expected 13", txr_n - b_txr); else passed++;
        total++; if (stall_bad !== 0) $display("FAIL mag_stall_pins: got %0d bad cycles expected 0", stall_bad); else passed++;
        total++; if (ss_mag - b_mag !== 81 || ss_ag - b_ag !== 0 || ss_alt - b_alt !== 0)
            $display("FAIL mag_cs_cycles: got mag=%0d ag=%0d alt=%0d expected 81/0/0", ss_mag - b_mag, ss_ag - b_ag, ss_alt - b_alt); else passed++;
        total++; if (rxv_n - b_rxv !== 2 || rx_prev !== 8'hA5 || rx_last !== 8'h3C)
            $display("FAIL mag_rx: got %0d pulses %h %h expected 2 pulses a5 3c", rxv_n - b_rxv, rx_prev, rx_last); else passed++;
        total++; if (mosi_sr[15:0] !== 16'hCF00) $display("FAIL mag_mosi: got %h expected cf00", mosi_sr[15:0]); else passed++;
        total++; if (done_n - b_done !== 1) $display("FAIL mag_done_once: got %0d expected 1", done_n - b_done); else passed++;
    endtask

    task automatic test_zero_len();
        int b_alt, b_tog, b_busy, b_done;
        b_alt = ss_alt; b_tog = sck_tog; b_busy = busy_n; b_done = done_n;
        issue_cmd(2'd2, 4'd0);
        @(negedge clk);
        total++; if (done !== 1'b1) $display("FAIL zero_done_pulse: got %b expected 1", done); else passed++;
        @(negedge clk);
        total++; if (done !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL zero_done_width: got done=%b ready=%b expected 0 1", done, cmd_ready); else passed++;
        repeat (4) @(negedge clk);
        total++; if (ss_alt - b_alt !== 0 || sck_tog - b_tog !== 0 || busy_n - b_busy !== 0 || done_n - b_done !== 1)
            $display("FAIL zero_no_activity: got cs=%0d sck=%0d busy=%0d done=%0d expected 0 0 0 1", ss_alt - b_alt, sck_tog - b_tog, busy_n - b_busy, done_n - b_done); else passed++;
    endtask

    task automatic test_back_to_back();
        int b_ag, b_mag, b_alt, b_done;
        bit ok1, ok2, ok3, ok4;
        miso_word = 32'h1234_0000;
        b_ag = ss_ag; b_mag = ss_mag; b_alt = ss_alt; b_done = done_n;
        issue_cmd(2'd0, 4'd1);
        send_byte(8'h5A, ok1);
        cmd_valid = 1'b1; cmd_dev = 2'd2; cmd_nbytes = 4'd3;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_busy_ready: got ready=%b busy=%b expected 0 1", cmd_ready, busy); else passed++;
        repeat (2) @(posedge clk); #1 cmd_valid = 1'b0;
        wait_done(ok2);
        issue_cmd(2'd1, 4'd1);
        send_byte(8'hA5, ok3);
        wait_done(ok4);
        total++; if (!(ok1 && ok2 && ok3 && ok4)) $display("FAIL b2b_timeout: got %b expected 1111", {ok1, ok2, ok3, ok4}); else passed++;
        @(negedge clk);
        // GAP 2 cycles + one IDLE cycle before the next command is taken
        total++; if (last_gap !== 3) $display("FAIL b2b_cs_gap: got %0d expected 3", last_gap); else passed++;
        total++; if (ss_ag - b_ag !== 37 || ss_mag - b_mag !== 37 || ss_alt - b_alt !== 0)
            $display("FAIL b2b_cs_cycles: got ag=%0d mag=%0d alt=%0d expected 37/37/0", ss_ag - b_ag, ss_mag - b_mag, ss_alt - b_alt); else passed++;
        total++; if (done_n - b_done !== 2) $display("FAIL b2b_done_count: got %0d expected 2", done_n - b_done); else passed++;
        total++; if (rx_data !== 8'h12) $display("FAIL b2b_rx: got %h expected 12", rx_data); else passed++;
    endtask

    task automatic test_fast();
        int b_tog;
        bit rdy, dn;
        miso_word_f = 32'hC300_0000;
        b_tog = f_tog;
        @(posedge clk); #1;
        cmd_valid_f = 1'b1; tx_data_f = 8'h3C; tx_valid_f = 1'b1;
        @(posedge clk); #1 cmd_valid_f = 1'b0;
        rdy = 1'b0;
        for (int i = 0; i < 100 && !rdy; i++) begin
            @(negedge clk);
            if (tx_ready_f === 1'b1) rdy = 1'b1;
        end
        @(posedge clk); #1 tx_valid_f = 1'b0;
        dn = 1'b0;
        for (int i = 0; i < 200 && !dn; i++) begin
            @(negedge clk);
            if (done_f === 1'b1) dn = 1'b1;
        end
        total++; if (!(rdy && dn)) $display("FAIL fast_timeout: got %b expected 11", {rdy, dn}); else passed++;
        total++; if (f_low_n !== 8 || f_tog - b_tog !== 16)
            $display("FAIL fast_sck: got low=%0d toggles=%0d expected 8 16", f_low_n, f_tog - b_tog); else passed++;
        total++; if (f_rxv_cyc - f_first_low_cyc !== 16)
            $display("FAIL fast_byte_time: got %0d expected 16", f_rxv_cyc - f_first_low_cyc); else passed++;
        total++; if (rx_data_f !== 8'hC3 || mosi_f !== 8'h3C)
            $display("FAIL fast_data: got rx=%h mosi=%h expected c3 3c", rx_data_f, mosi_f); else passed++;
    endtask

    task automatic test_reset_mid();
        int b_mosi, b_done, b_rxv;
        bit ok;
        miso_word = 32'hFFFF_0000;
        b_mosi = mosi_n;
        issue_cmd(2'd0, 4'd1);
        send_byte(8'hAA, ok);
        for (int i = 0; i < 200 && (mosi_n - b_mosi) < 4; i++) @(negedge clk);
        total++; if (!ok || (mosi_n - b_mosi) < 4) $display("FAIL mid_reach_bit4: got %0d rises expected 4", mosi_n - b_mosi); else passed++;
        b_done = done_n; b_rxv = rxv_n;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if ({ss_o, sck_o, io0_o, io0_t, sck_t, ss_t, busy, done, rx_valid} !== 11'b111_1_1_1_1_1_0_0_0)
            $display("FAIL mid_reset_pins: got %b expected 11111111000", {ss_o, sck_o, io0_o, io0_t, sck_t, ss_t, busy, done, rx_valid}); else passed++;
        total++; if (rx_data !== 8'h00) $display("FAIL mid_reset_rx_data: got %h expected 00", rx_data); else passed++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        total++; if ({io0_t, sck_t, ss_t, cmd_ready} !== 4'b0001) $display("FAIL mid_release: got %b expected 0001", {io0_t, sck_t, ss_t, cmd_ready}); else passed++;
        repeat (40) @(negedge clk);
        total++; if (done_n - b_done !== 0 || rxv_n - b_rxv !== 0 || ss_o !== 3'b111)
            $display("FAIL mid_no_completion: got done=%0d rxv=%0d ss=%b expected 0 0 111", done_n - b_done, rxv_n - b_rxv, ss_o); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_ag();
        test_mag_stall();
        test_zero_len();
        test_back_to_back();
        test_fast();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
